spi_io_expander_n: RTL and testbench

Parametrised SPI-controlled I/O expander: a single-clock SPI mode-0 slave driving NUM_BANKS 8-bit banks of output, output-enable and sampled-input registers. It adds multi-bank addressing, set/clear/readback commands, burst auto-increment and error status. It sits between the chip-level io_in/io_out pins and the project pads, and replaces the fixed 8-bit expander core.

---
 rtl/spi_io_expander_n_pkg.sv | 44 ++++
 rtl/spi_exp_sync.sv | 31 +++
 rtl/spi_io_expander_n.sv | 146 ++++++++++++++
 tb/tb_spi_io_expander_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_io_expander_n_pkg.sv
// Shared definitions for the SPI I/O expander: opcodes, register selects,
// FSM states, STATUS bit positions and the byte-commit record.
package spi_io_expander_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLR   = 2'd3;

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_OE   = 2'd1;
  localparam logic [1:0] REG_IN   = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int STAT_FERR = 0;
  localparam int STAT_AERR = 1;

  // One completed data byte, applied to the register file a cycle later.
  typedef struct packed {
    logic       vld;
    logic [1:0] op;
    logic [1:0] rsel;
    logic [3:0] bank;
    logic       oor;
    logic [7:0] data;
  } commit_t;

  function automatic logic [7:0] apply_op(input logic [1:0] op,
                                          input logic [7:0] cur,
                                          input logic [7:0] d);
    case (op)
      OP_SET:  return cur | d;
      OP_CLR:  return cur & ~d;
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/spi_exp_sync.sv
// Multi-flop synchroniser with rise/fall detect on the synchronised level.
module spi_exp_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_io_expander_n.sv
// SPI mode-0 slave controlling NUM_BANKS 8-bit banks of OUT/OE/IN registers,
// with set/clear ops, burst auto-increment and sticky error status.
module spi_io_expander_n
  import spi_io_expander_n_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ss_n_i,
  input  logic                   sclk_i,
  input  logic                   mosi_i,
  output logic                   miso_o,
  input  logic [8*NUM_BANKS-1:0] gpio_in_i,
  output logic [8*NUM_BANKS-1:0] gpio_out_o,
  output logic [8*NUM_BANKS-1:0] gpio_oe_o,
  output logic                   frame_err_o
);

  localparam logic [3:0] LAST_BANK = 4'(NUM_BANKS - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sclk_unused_lvl, ss_unused_lvl, mosi_unused_r, mosi_unused_f;
  logic [8*NUM_BANKS-1:0] gin_s, gin_unused_r, gin_unused_f;

  spi_exp_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i, .rst_i, .d_i(sclk_i), .q_o(sclk_unused_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_exp_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ss (
    .clk_i, .rst_i, .d_i(ss_n_i), .q_o(ss_unused_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_exp_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i, .rst_i, .d_i(mosi_i), .q_o(mosi_s), .rise_o(mosi_unused_r), .fall_o(mosi_unused_f));
  spi_exp_sync #(.WIDTH(8*NUM_BANKS), .STAGES(SYNC_STAGES)) u_sync_gin (
    .clk_i, .rst_i, .d_i(gpio_in_i), .q_o(gin_s), .rise_o(gin_unused_r), .fall_o(gin_unused_f));

  state_e                 state_q;
  logic [2:0]             cnt_q;
  logic [6:0]             rx_q;
  logic [7:0]             tx_q;
  logic                   miso_q, ferr_pulse_q, aerr_q, ferr_q, oor_q;
  logic [1:0]             op_q, rsel_q;
  logic [3:0]             bank_q;
  commit_t                cm_q;
  logic [8*NUM_BANKS-1:0] out_q, oe_q;

  logic [7:0] rx_nxt, rd_byte, status;
  logic [2:0] cnt_nxt;
  logic [3:0] bank_inc, ld_bank;
  logic [1:0] ld_op, ld_rsel;
  logic       byte_done, cmd_oor, ld_oor;

  assign status = {LAST_BANK, 2'b00, aerr_q, ferr_q};

  // ld_* is the command context for the byte that starts after this boundary.
  always_comb begin
    rx_nxt    = {rx_q, mosi_s};
    cnt_nxt   = (sclk_rise && state_q != ST_IDLE) ? cnt_q + 3'd1 : cnt_q;
    byte_done = sclk_rise && (state_q != ST_IDLE) && (cnt_q == 3'd7);
    bank_inc  = (bank_q == LAST_BANK) ? 4'd0 : bank_q + 4'd1;
    cmd_oor   = (rx_nxt[5:4] != REG_STAT) && ({1'b0, rx_nxt[3:0]} >= 5'(NUM_BANKS));
    if (state_q == ST_CMD) begin
      ld_op = rx_nxt[7:6]; ld_rsel = rx_nxt[5:4]; ld_bank = rx_nxt[3:0]; ld_oor = cmd_oor;
    end else begin
      ld_op = op_q; ld_rsel = rsel_q; ld_bank = oor_q ? bank_q : bank_inc; ld_oor = oor_q;
    end
    rd_byte = '0;
    if (!ld_oor) begin
      if (ld_rsel == REG_STAT) rd_byte = status;
      else
        for (int b = 0; b < NUM_BANKS; b++)
          if (ld_bank == 4'(b))
            case (ld_rsel)
              REG_OUT: rd_byte = out_q[b*8 +: 8];
              REG_OE:  rd_byte = oe_q[b*8 +: 8];
              default: rd_byte = gin_s[b*8 +: 8];
            endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE; cnt_q <= '0; rx_q <= '0; tx_q <= '0; miso_q <= 1'b0;
      op_q <= '0; rsel_q <= '0; bank_q <= '0; oor_q <= 1'b0;
      ferr_pulse_q <= 1'b0; aerr_q <= 1'b0; ferr_q <= 1'b0; cm_q <= '0;
    end else begin
      ferr_pulse_q <= 1'b0;
      cm_q.vld     <= 1'b0;
      if (cm_q.vld && cm_q.rsel == REG_STAT) begin
        if (cm_q.data[STAT_FERR]) ferr_q <= 1'b0;
        if (cm_q.data[STAT_AERR]) aerr_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            state_q <= ST_CMD; cnt_q <= '0; tx_q <= '0;
          end
        end
        default: begin
          if (sclk_rise) begin
            rx_q  <= rx_nxt[6:0];
            cnt_q <= cnt_nxt;
          end
          if (sclk_fall) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
          if (byte_done) begin
            op_q <= ld_op; rsel_q <= ld_rsel; bank_q <= ld_bank; oor_q <= ld_oor;
            tx_q <= (ld_op == OP_READ) ? rd_byte : 8'h00;
            if (state_q == ST_CMD) begin
              state_q <= ST_DATA;
              if (ld_oor) begin aerr_q <= 1'b1; ferr_pulse_q <= 1'b1; end
            end else if (op_q != OP_READ) begin
              cm_q <= '{vld: 1'b1, op: op_q, rsel: rsel_q, bank: bank_q, oor: oor_q, data: rx_nxt};
            end
          end
          // A rise landing with the final bit has already completed the byte above.
          if (ss_rise) begin
            state_q <= ST_IDLE; miso_q <= 1'b0;
            if (cnt_nxt != 3'd0) begin ferr_pulse_q <= 1'b1; ferr_q <= 1'b1; end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
      oe_q  <= '0;
    end else if (cm_q.vld && !cm_q.oor) begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (cm_q.bank == 4'(b)) begin
          if (cm_q.rsel == REG_OUT) out_q[b*8 +: 8] <= apply_op(cm_q.op, out_q[b*8 +: 8], cm_q.data);
          if (cm_q.rsel == REG_OE)  oe_q[b*8 +: 8]  <= apply_op(cm_q.op, oe_q[b*8 +: 8], cm_q.data);
        end
    end
  end

  assign miso_o      = miso_q;
  assign frame_err_o = ferr_pulse_q;
  assign gpio_out_o  = out_q;
  assign gpio_oe_o   = oe_q;

endmodule

// File: tb/tb_spi_io_expander_n.sv
// Directed bench for spi_io_expander_n: NUM_BANKS=4, sclk = clk/8.
module tb_spi_io_expander_n;
  localparam int NB = 4;
  localparam int SS = 2;

  logic clk = 1'b0, rst = 1'b1, ss_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic miso, frame_err;
  logic [8*NB-1:0] gpio_in = '0, gpio_out, gpio_oe;
  int errors = 0, checks = 0, ferr_cnt = 0;
  logic miso_smp;

  spi_io_expander_n #(.NUM_BANKS(NB), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst), .ss_n_i(ss_n), .sclk_i(sclk), .mosi_i(mosi),
    .miso_o(miso), .gpio_in_i(gpio_in), .gpio_out_o(gpio_out),
    .gpio_oe_o(gpio_oe), .frame_err_o(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_err) ferr_cnt <= ferr_cnt + 1;

  task automatic bit_lo(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    miso_smp = miso;
    sclk = 1'b1;
  endtask

  task automatic bit_hi();
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bit_lo(tx[i]);
      rx[i] = miso_smp;
      bit_hi();
    end
  endtask

  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int n, output logic [7:0] rx);
    logic [7:0] bs [4];
    bs = '{b0, b1, b2, b3};
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) spi_byte(bs[i], rx);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (gpio_out !== '0) begin errors++; $display("FAIL reset_out: got %h exp 0", gpio_out); end
    checks++; if (gpio_oe !== '0) begin errors++; $display("FAIL reset_oe: got %h exp 0", gpio_oe); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b exp 0", miso); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_latency();
    logic [7:0] rx, d;
    int lat;
    d = 8'hA5;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h02, rx);
    for (int i = 7; i >= 1; i--) begin bit_lo(d[i]); bit_hi(); end
    mosi = d[0];
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (lat < 0 && gpio_out[23:16] == 8'hA5) lat = k;
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (lat != SS + 2) begin errors++; $display("FAIL wr_latency: got %0d exp %0d", lat, SS + 2); end
    checks++; if (gpio_out !== 32'h00A5_0000) begin errors++; $display("FAIL wr_out: got %h exp 00a50000", gpio_out); end
    checks++; if (gpio_oe !== 32'h0) begin errors++; $display("FAIL wr_oe: got %h exp 0", gpio_oe); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx;
    spi_frame(8'h13, 8'h11, 8'h22, 8'h33, 4, rx);
    checks++; if (gpio_oe !== 32'h1100_3322) begin errors++; $display("FAIL burst_oe: got %h exp 11003322", gpio_oe); end
    checks++; if (gpio_out !== 32'h00A5_0000) begin errors++; $display("FAIL burst_out: got %h exp 00a50000", gpio_out); end
  endtask

  task automatic test_set_clear();
    logic [7:0] rx;
    spi_frame(8'h00, 8'hF0, 8'h00, 8'h00, 2, rx);
    spi_frame(8'h80, 8'h0F, 8'h00, 8'h00, 2, rx);
    checks++; if (gpio_out !== 32'h00A5_00FF) begin errors++; $display("FAIL set_out: got %h exp 00a500ff", gpio_out); end
    spi_frame(8'hC0, 8'h3C, 8'h00, 8'h00, 2, rx);
    checks++; if (gpio_out !== 32'h00A5_00C3) begin errors++; $display("FAIL clr_out: got %h exp 00a500c3", gpio_out); end
  endtask

  task automatic test_read();
    logic [7:0] rx;
    int f0;
    gpio_in = 32'h0000_5A00;
    repeat (4) @(negedge clk);
    f0 = ferr_cnt;
    spi_frame(8'h61, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL read_in: got %h exp 5a", rx); end
    spi_frame(8'h70, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h30) begin errors++; $display("FAIL read_stat: got %h exp 30", rx); end
    checks++; if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL read_ferr: got %0d pulses exp 0", ferr_cnt - f0); end
  endtask

  task automatic test_addr_err();
    logic [7:0] rx;
    int f0;
    f0 = ferr_cnt;
    spi_frame(8'h05, 8'hFF, 8'h00, 8'h00, 2, rx);
    checks++; if (gpio_out !== 32'h00A5_00C3) begin errors++; $display("FAIL oor_out: got %h exp 00a500c3", gpio_out); end
    checks++; if (gpio_oe !== 32'h1100_3322) begin errors++; $display("FAIL oor_oe: got %h exp 11003322", gpio_oe); end
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL oor_pulse: got %0d exp 1", ferr_cnt - f0); end
    spi_frame(8'h70, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h32) begin errors++; $display("FAIL oor_stat: got %h exp 32", rx); end
    spi_frame(8'h30, 8'h02, 8'h00, 8'h00, 2, rx);
    spi_frame(8'h70, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h30) begin errors++; $display("FAIL oor_clr: got %h exp 30", rx); end
    gpio_in = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    f0 = ferr_cnt;
    spi_frame(8'h66, 8'h00, 8'h00, 8'h00, 3, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL oor_read: got %h exp 00", rx); end
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL oor_read_pulse: got %0d exp 1", ferr_cnt - f0); end
    spi_frame(8'h30, 8'h02, 8'h00, 8'h00, 2, rx);
    gpio_in = '0;
  endtask

  task automatic test_partial();
    logic [7:0] rx;
    int f0;
    f0 = ferr_cnt;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h01, rx);
    for (int i = 0; i < 4; i++) begin bit_lo(1'b1); bit_hi(); end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (gpio_out !== 32'h00A5_00C3) begin errors++; $display("FAIL part_out: got %h exp 00a500c3", gpio_out); end
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL part_pulse: got %0d exp 1", ferr_cnt - f0); end
    spi_frame(8'h70, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h31) begin errors++; $display("FAIL part_stat: got %h exp 31", rx); end
    f0 = ferr_cnt;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h07, rx);
    for (int i = 0; i < 3; i++) begin bit_lo(1'b0); bit_hi(); end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (ferr_cnt - f0 != 2) begin errors++; $display("FAIL two_err_pulses: got %0d exp 2", ferr_cnt - f0); end
    spi_frame(8'h70, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h33) begin errors++; $display("FAIL two_err_stat: got %h exp 33", rx); end
    spi_frame(8'h30, 8'h03, 8'h00, 8'h00, 2, rx);
    spi_frame(8'h70, 8'h00, 8'h00, 8'h00, 2, rx);
    checks++; if (rx !== 8'h30) begin errors++; $display("FAIL stat_clr: got %h exp 30", rx); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int f0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h01, rx);
    bit_lo(1'b1); bit_hi();
    bit_lo(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (gpio_out !== '0) begin errors++; $display("FAIL rmid_out: got %h exp 0", gpio_out); end
    checks++; if (gpio_oe !== '0) begin errors++; $display("FAIL rmid_oe: got %h exp 0", gpio_oe); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rmid_miso: got %b exp 0", miso); end
    rst = 1'b0;
    f0 = ferr_cnt;
    bit_hi();
    spi_byte(8'h02, rx);
    spi_byte(8'hEE, rx);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (gpio_out !== '0) begin errors++; $display("FAIL rmid_ignored: got %h exp 0", gpio_out); end
    checks++; if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL rmid_ferr: got %0d exp 0", ferr_cnt - f0); end
    spi_frame(8'h02, 8'h77, 8'h00, 8'h00, 2, rx);
    checks++; if (gpio_out !== 32'h0077_0000) begin errors++; $display("FAIL rmid_frame: got %h exp 00770000", gpio_out); end
    checks++; if (gpio_oe !== '0) begin errors++; $display("FAIL rmid_frame_oe: got %h exp 0", gpio_oe); end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_burst_wrap();
    test_set_clear();
    test_read();
    test_addr_err();
    test_partial();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
